// File: rtl/arp_cam_insert_ctrl.sv
// Insert controller for the ARP CAM: scans a shadow of the CAM keys for the request's IP,
// then writes it over the matching entry, the lowest free entry, or a pseudo-random victim.
module arp_cam_insert_ctrl #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned IDXW  = 3
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [15:0]     rnd_i,
  input  logic            flush_i,
  input  logic            ins_valid_i,
  output logic            ins_ready_o,
  input  logic [31:0]     ins_ip_i,
  input  logic [47:0]     ins_mac_i,
  output logic            wr_en_o,
  output logic [IDXW-1:0] wr_idx_o,
  output logic [31:0]     wr_ip_o,
  output logic [47:0]     wr_mac_o,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [IDXW-1:0] rsp_idx_o,
  output logic [1:0]      rsp_kind_o
);

  typedef enum logic [1:0] {StIdle, StSearch, StWrite, StResp} state_e;

  localparam logic [1:0]      KindUpdate = 2'b01;
  localparam logic [1:0]      KindNew    = 2'b10;
  localparam logic [1:0]      KindEvict  = 2'b11;
  localparam logic [IDXW-1:0] LastIdx    = IDXW'(DEPTH - 1);

  state_e          state_q;
  logic            rdy_en_q;
  logic [DEPTH-1:0] valid_q;
  logic [31:0]     key_q [DEPTH];
  logic [31:0]     ip_q;
  logic [47:0]     mac_q;
  logic [IDXW-1:0] scan_q;
  logic            cmp_vld_q;
  logic            cmp_hit_q;
  logic            cmp_free_q;
  logic [IDXW-1:0] cmp_idx_q;
  logic            free_found_q;
  logic [IDXW-1:0] free_idx_q;
  logic [IDXW-1:0] tgt_q;
  logic [1:0]      kind_q;
  logic            wr_en_q;
  logic            rsp_valid_q;

  logic            cur_hit;
  logic            free_any;
  logic [IDXW-1:0] free_sel;
  logic            unused_rnd;

  assign unused_rnd = ^rnd_i[15:IDXW];

  // The compare result is registered, so each entry is decided one cycle after it is read.
  assign cur_hit  = valid_q[scan_q] && (key_q[scan_q] == ip_q);
  assign free_any = free_found_q || cmp_free_q;
  assign free_sel = free_found_q ? free_idx_q : cmp_idx_q;

  assign ins_ready_o = rdy_en_q && (state_q == StIdle) && !flush_i;
  assign wr_en_o     = wr_en_q;
  assign wr_idx_o    = tgt_q;
  assign wr_ip_o     = ip_q;
  assign wr_mac_o    = mac_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_idx_o   = tgt_q;
  assign rsp_kind_o  = kind_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      rdy_en_q     <= 1'b0;
      valid_q      <= '0;
      ip_q         <= '0;
      mac_q        <= '0;
      scan_q       <= '0;
      cmp_vld_q    <= 1'b0;
      cmp_hit_q    <= 1'b0;
      cmp_free_q   <= 1'b0;
      cmp_idx_q    <= '0;
      free_found_q <= 1'b0;
      free_idx_q   <= '0;
      tgt_q        <= '0;
      kind_q       <= 2'b00;
      wr_en_q      <= 1'b0;
      rsp_valid_q  <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (flush_i) begin
            valid_q <= '0;
          end else if (ins_valid_i && ins_ready_o) begin
            ip_q         <= ins_ip_i;
            mac_q        <= ins_mac_i;
            scan_q       <= '0;
            cmp_vld_q    <= 1'b0;
            free_found_q <= 1'b0;
            state_q      <= StSearch;
          end
        end
        StSearch: begin
          if (cmp_vld_q && cmp_hit_q) begin
            tgt_q   <= cmp_idx_q;
            kind_q  <= KindUpdate;
            wr_en_q <= 1'b1;
            state_q <= StWrite;
          end else if (cmp_vld_q && (cmp_idx_q == LastIdx)) begin
            tgt_q   <= free_any ? free_sel : rnd_i[IDXW-1:0];
            kind_q  <= free_any ? KindNew : KindEvict;
            wr_en_q <= 1'b1;
            state_q <= StWrite;
          end else begin
            if (cmp_vld_q && cmp_free_q && !free_found_q) begin
              free_found_q <= 1'b1;
              free_idx_q   <= cmp_idx_q;
            end
            cmp_vld_q  <= 1'b1;
            cmp_hit_q  <= cur_hit;
            cmp_free_q <= !valid_q[scan_q];
            cmp_idx_q  <= scan_q;
            scan_q     <= scan_q + IDXW'(1);
          end
        end
        StWrite: begin
          valid_q[tgt_q] <= 1'b1;
          wr_en_q        <= 1'b0;
          rsp_valid_q    <= 1'b1;
          state_q        <= StResp;
        end
        StResp: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Keys are only meaningful under their valid bit, so they need no reset.
  always_ff @(posedge clk_i) begin
    if (state_q == StWrite) begin
      key_q[tgt_q] <= ip_q;
    end
  end

endmodule

// File: tb/tb_arp_cam_insert_ctrl.sv
// Directed bench for arp_cam_insert_ctrl: hand-computed latencies, indices and kinds per scenario.
module tb_arp_cam_insert_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [15:0] rnd_i = 16'h1234;
  logic        flush_i = 1'b0;
  logic        ins_valid_i = 1'b0;
  logic        ins_ready_o;
  logic [31:0] ins_ip_i = '0;
  logic [47:0] ins_mac_i = '0;
  logic        wr_en_o;
  logic [2:0]  wr_idx_o;
  logic [31:0] wr_ip_o;
  logic [47:0] wr_mac_o;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [2:0]  rsp_idx_o;
  logic [1:0]  rsp_kind_o;

  int vectors = 0;
  int miscompares = 0;

  arp_cam_insert_ctrl #(.DEPTH(8), .IDXW(3)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .rnd_i       (rnd_i),
    .flush_i     (flush_i),
    .ins_valid_i (ins_valid_i),
    .ins_ready_o (ins_ready_o),
    .ins_ip_i    (ins_ip_i),
    .ins_mac_i   (ins_mac_i),
    .wr_en_o     (wr_en_o),
    .wr_idx_o    (wr_idx_o),
    .wr_ip_o     (wr_ip_o),
    .wr_mac_o    (wr_mac_o),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_idx_o   (rsp_idx_o),
    .rsp_kind_o  (rsp_kind_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Runs one insert; lat counts cycles from the accepting edge to the cycle WrEn is seen.
  task automatic do_insert(input logic [31:0] ip, input logic [47:0] mac, input int flush_cyc,
                           output int lat, output logic [2:0] widx, output logic [31:0] wip,
                           output logic [47:0] wmac, output logic [2:0] ridx,
                           output logic [1:0] rkind, output int pulses, output bit to);
    lat = 0; widx = '0; wip = '0; wmac = '0; ridx = '0; rkind = '0; pulses = 0; to = 1'b0;
    for (int i = 0; i < 10 && !ins_ready_o; i++) tick();
    if (!ins_ready_o) begin to = 1'b1; return; end
    ins_valid_i = 1'b1; ins_ip_i = ip; ins_mac_i = mac;
    tick();
    ins_valid_i = 1'b0;
    while (!wr_en_o && lat < 40) begin
      if (lat == flush_cyc) flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      lat++;
    end
    if (!wr_en_o) begin to = 1'b1; return; end
    widx = wr_idx_o; wip = wr_ip_o; wmac = wr_mac_o; pulses = 1;
    tick();
    for (int i = 0; i < 10 && !rsp_valid_o; i++) begin
      if (wr_en_o) pulses++;
      tick();
    end
    if (wr_en_o) pulses++;
    if (!rsp_valid_o) begin to = 1'b1; return; end
    ridx = rsp_idx_o; rkind = rsp_kind_o;
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
  endtask

  int          lat;
  logic [2:0]  widx;
  logic [31:0] wip;
  logic [47:0] wmac;
  logic [2:0]  ridx;
  logic [1:0]  rkind;
  int          pulses;
  bit          to;

  task automatic test_reset();
    tick(); tick();
    vectors++;
    if ({wr_en_o, rsp_valid_o, rsp_idx_o, rsp_kind_o, wr_idx_o} !== 9'b0) begin
      miscompares++;
      $display("FAIL reset_ctl: got we=%b rv=%b ri=%0d rk=%b wi=%0d want all 0",
               wr_en_o, rsp_valid_o, rsp_idx_o, rsp_kind_o, wr_idx_o);
    end
    vectors++;
    if ({wr_ip_o, wr_mac_o} !== 80'h0) begin
      miscompares++; $display("FAIL reset_data: got ip=%h mac=%h want 0", wr_ip_o, wr_mac_o);
    end
    vectors++;
    if (ins_ready_o !== 1'b0) begin
      miscompares++; $display("FAIL reset_ready: got %b want 0", ins_ready_o);
    end
    rst_ni = 1'b1;
    tick();
    vectors++;
    if (ins_ready_o !== 1'b1) begin
      miscompares++; $display("FAIL ready_after_reset: got %b want 1", ins_ready_o);
    end
  endtask

  task automatic test_new_insert();
    do_insert(32'h0A000001, 48'h00005E000001, -1, lat, widx, wip, wmac, ridx, rkind, pulses, to);
    vectors++;
    if ({to, lat, widx, ridx, rkind, pulses} !== {1'b0, 32'd9, 3'd0, 3'd0, 2'b10, 32'd1}) begin
      miscompares++;
      $display("FAIL new: got to=%0d lat=%0d wi=%0d ri=%0d kind=%b pulses=%0d want 0 9 0 0 10 1",
               to, lat, widx, ridx, rkind, pulses);
    end
    vectors++;
    if ({wip, wmac} !== {32'h0A000001, 48'h00005E000001}) begin
      miscompares++; $display("FAIL new_data: got ip=%h mac=%h want 0a000001 00005e000001", wip, wmac);
    end
  endtask

  task automatic test_update();
    do_insert(32'h0A000001, 48'h00005E000002, -1, lat, widx, wip, wmac, ridx, rkind, pulses, to);
    vectors++;
    if ({to, lat, widx, ridx, rkind, pulses} !== {1'b0, 32'd2, 3'd0, 3'd0, 2'b01, 32'd1}) begin
      miscompares++;
      $display("FAIL update: got to=%0d lat=%0d wi=%0d ri=%0d kind=%b pulses=%0d want 0 2 0 0 01 1",
               to, lat, widx, ridx, rkind, pulses);
    end
    vectors++;
    if (wmac !== 48'h00005E000002) begin
      miscompares++; $display("FAIL update_mac: got %h want 00005e000002", wmac);
    end
  endtask

  task automatic test_fill_evict();
    for (int i = 1; i < 8; i++) begin
      do_insert(32'h0A000001 + i, 48'h0 + i, -1, lat, widx, wip, wmac, ridx, rkind, pulses, to);
      vectors++;
      if ({to, lat, widx, rkind} !== {1'b0, 32'd9, 3'(i), 2'b10}) begin
        miscompares++;
        $display("FAIL fill_%0d: got to=%0d lat=%0d wi=%0d kind=%b want 0 9 %0d 10",
                 i, to, lat, widx, rkind, i);
      end
    end
    rnd_i = 16'hABCD;
    do_insert(32'h0A000063, 48'h99, -1, lat, widx, wip, wmac, ridx, rkind, pulses, to);
    vectors++;
    if ({to, lat, widx, ridx, rkind} !== {1'b0, 32'd9, 3'd5, 3'd5, 2'b11}) begin
      miscompares++;
      $display("FAIL evict: got to=%0d lat=%0d wi=%0d ri=%0d kind=%b want 0 9 5 5 11",
               to, lat, widx, ridx, rkind);
    end
    rnd_i = 16'h1234;
    // Entry 5 now holds the new key: re-inserting matches there.
    do_insert(32'h0A000063, 48'h9A, -1, lat, widx, wip, wmac, ridx, rkind, pulses, to);
    vectors++;
    if ({to, lat, widx, rkind} !== {1'b0, 32'd7, 3'd5, 2'b01}) begin
      miscompares++;
      $display("FAIL evict_key: got to=%0d lat=%0d wi=%0d kind=%b want 0 7 5 01",
               to, lat, widx, rkind);
    end
  endtask

  task automatic test_rsp_hold();
    int wr_at;
    wr_at = -1;
    pulses = 0;
    for (int i = 0; i < 10 && !ins_ready_o; i++) tick();
    ins_valid_i = 1'b1; ins_ip_i = 32'h0A000002; ins_mac_i = 48'h55;
    tick();
    ins_valid_i = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      tick();
      if (wr_en_o) begin pulses++; wr_at = i; end
      if (i >= 4) begin
        vectors++;
        if ({rsp_valid_o, rsp_idx_o, rsp_kind_o, ins_ready_o} !== {1'b1, 3'd1, 2'b01, 1'b0}) begin
          miscompares++;
          $display("FAIL hold_c%0d: got rv=%b ri=%0d rk=%b rdy=%b want 1 1 01 0",
                   i, rsp_valid_o, rsp_idx_o, rsp_kind_o, ins_ready_o);
        end
      end
    end
    vectors++;
    if ({pulses, wr_at} !== {32'd1, 32'd3}) begin
      miscompares++; $display("FAIL hold_wr: got pulses=%0d at=%0d want 1 at 3", pulses, wr_at);
    end
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    vectors++;
    if ({rsp_valid_o, ins_ready_o} !== 2'b01) begin
      miscompares++;
      $display("FAIL hold_release: got rv=%b rdy=%b want 0 1", rsp_valid_o, ins_ready_o);
    end
  endtask

  task automatic test_flush();
    flush_i = 1'b1; ins_valid_i = 1'b1; ins_ip_i = 32'h0A000003;
    #1;
    vectors++;
    if (ins_ready_o !== 1'b0) begin
      miscompares++; $display("FAIL flush_ready: got %b want 0", ins_ready_o);
    end
    tick();
    flush_i = 1'b0; ins_valid_i = 1'b0;
    do_insert(32'h0A000063, 48'hA1, 3, lat, widx, wip, wmac, ridx, rkind, pulses, to);
    vectors++;
    if ({to, lat, widx, ridx, rkind} !== {1'b0, 32'd9, 3'd0, 3'd0, 2'b10}) begin
      miscompares++;
      $display("FAIL flush_new: got to=%0d lat=%0d wi=%0d ri=%0d kind=%b want 0 9 0 0 10",
               to, lat, widx, ridx, rkind);
    end
    // A flush pulse mid-search must not wipe entry 0.
    do_insert(32'h0A000077, 48'hA2, 4, lat, widx, wip, wmac, ridx, rkind, pulses, to);
    vectors++;
    if ({to, lat, widx, rkind} !== {1'b0, 32'd9, 3'd1, 2'b10}) begin
      miscompares++;
      $display("FAIL flush_search: got to=%0d lat=%0d wi=%0d kind=%b want 0 9 1 10",
               to, lat, widx, rkind);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    seen = 0;
    for (int i = 0; i < 10 && !ins_ready_o; i++) tick();
    ins_valid_i = 1'b1; ins_ip_i = 32'h0A0000F0; ins_mac_i = 48'hF0;
    tick();
    ins_valid_i = 1'b0;
    tick(); tick(); tick();
    rst_ni = 1'b0;
    #1;
    vectors++;
    if ({wr_en_o, rsp_valid_o, rsp_idx_o, rsp_kind_o, wr_idx_o, ins_ready_o} !== 10'b0) begin
      miscompares++;
      $display("FAIL midrst_ctl: got we=%b rv=%b ri=%0d rk=%b wi=%0d rdy=%b want all 0",
               wr_en_o, rsp_valid_o, rsp_idx_o, rsp_kind_o, wr_idx_o, ins_ready_o);
    end
    vectors++;
    if ({wr_ip_o, wr_mac_o} !== 80'h0) begin
      miscompares++; $display("FAIL midrst_data: got ip=%h mac=%h want 0", wr_ip_o, wr_mac_o);
    end
    tick(); tick();
    rst_ni = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (wr_en_o || rsp_valid_o) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++; $display("FAIL midrst_abort: got %0d active cycles want 0", seen);
    end
    // Entry 0 held 0x0A000063; cleared valid bits make this a fresh NEW at 0.
    do_insert(32'h0A000063, 48'hB1, -1, lat, widx, wip, wmac, ridx, rkind, pulses, to);
    vectors++;
    if ({to, lat, widx, rkind} !== {1'b0, 32'd9, 3'd0, 2'b10}) begin
      miscompares++;
      $display("FAIL midrst_cleared: got to=%0d lat=%0d wi=%0d kind=%b want 0 9 0 10",
               to, lat, widx, rkind);
    end
  endtask

  initial begin
    test_reset();
    test_new_insert();
    test_update();
    test_fill_evict();
    test_rsp_hold();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/arp_cam_insert_ctrl.md
ARP_CAM_INSERT_CTRL -- requirements
Module: arp_cam_insert_ctrl

Interface
REQ-001 Parameter DEPTH, default 8: number of CAM entries; power of two, 2..64.
REQ-002 Parameter IDXW, default 3: log2(DEPTH), the entry index width.
REQ-003 Clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Rst_n  input  1  asynchronous active-low reset.
REQ-005 Rnd  input  16  free-running pseudo-random word from the ARP CAM LFSR, which updates every cycle.
REQ-006 Flush  input  1  level request to invalidate all entries.
REQ-007 InsValid  input  1  insert request valid.
REQ-008 InsReady  output  1  insert request accepted when InsValid && InsReady.
REQ-009 InsIp  input  32  IPv4 key of the request.
REQ-010 InsMac  input  48  MAC value of the request.
REQ-011 WrEn  output  1  one-cycle CAM storage write strobe.
REQ-012 WrIdx  output  IDXW  entry index written.
REQ-013 WrIp / WrMac  output  32 / 48  key and value written.
REQ-014 RspValid  output  1  completion valid.
REQ-015 RspReady  input  1  completion accepted when RspValid && RspReady.
REQ-016 RspIdx / RspKind  output  IDXW / 2  completed index; kind 01=UPDATE, 10=NEW, 11=EVICT.

Function
REQ-017 The block SHALL hold an internal shadow of DEPTH valid bits and DEPTH 32-bit IP keys, mirroring every write it issues.
REQ-018 FSM states SHALL be IDLE, SEARCH, WRITE and RESP.
REQ-019 InsReady SHALL equal (state==IDLE && !Flush).
REQ-020 In IDLE with Flush=1, all valid bits SHALL clear in that cycle, and no request SHALL be accepted that cycle.
REQ-021 Flush SHALL be ignored outside IDLE and acted upon once the FSM returns to IDLE if still asserted.
REQ-022 On acceptance, InsIp/InsMac SHALL be registered and the FSM SHALL enter SEARCH with scan index 0.
REQ-023 SEARCH SHALL examine one entry per cycle, in index order 0..DEPTH-1.
- On a valid entry whose key equals the registered IP: target = that index, kind = UPDATE, go to WRITE next cycle.
- First invalid entry seen: recorded as free candidate; scanning continues.
REQ-024 After entry DEPTH-1 is examined without a match, the target SHALL be chosen as follows, and the FSM SHALL go to WRITE:
- If a free candidate was recorded: target = lowest invalid index, kind = NEW.
- Otherwise: target = Rnd[IDXW-1:0] sampled in that last SEARCH cycle, kind = EVICT.
REQ-025 In WRITE, WrEn SHALL be 1 for exactly one cycle with WrIdx=target, WrIp/WrMac = registered request; the shadow SHALL be updated with valid=1 and key=IP in that same edge; the FSM SHALL then go to RESP.
REQ-026 Latency SHALL be: match at entry k gives WrEn k+2 cycles after the accepting edge; no match gives WrEn DEPTH+1 cycles after it.
REQ-027 In RESP, RspValid=1 with stable RspIdx/RspKind SHALL hold until RspReady=1; the FSM SHALL then return to IDLE on that edge.
REQ-028 Back-to-back inserts SHALL see the shadow updated by the previous insert; duplicates therefore report UPDATE.
REQ-029 WrEn SHALL be 0 in every state other than WRITE.
REQ-030 WrIp/WrMac/WrIdx SHALL be don't-care when WrEn=0 but SHALL NOT toggle X after reset.

Reset
REQ-031 While Rst_n=0: state=IDLE, all valid bits 0, WrEn=0, RspValid=0, RspIdx=0, RspKind=00, WrIdx=0, WrIp=0, WrMac=0.
REQ-032 InsReady SHALL be 0 while Rst_n=0 and SHALL follow REQ-019 from the first edge after release.
REQ-033 Reset asserted mid-operation SHALL abort the operation with no further WrEn or RspValid.

Verification
REQ-034 Empty CAM, insert IP 0x0A000001 / MAC 0x0000_5E00_0001 -> WrEn 9 cycles after accept, WrIdx=0, RspKind=NEW, RspIdx=0.
REQ-035 Repeat the same IP with MAC 0x0000_5E00_0002 -> match at entry 0, WrEn 2 cycles after accept, WrIdx=0, RspKind=UPDATE.
REQ-036 Fill 8 distinct IPs, then insert a ninth with Rnd forced to 0xABCD in the last SEARCH cycle -> WrIdx=5, RspKind=EVICT; the shadow key at index 5 becomes the new IP.
REQ-037 Hold RspReady=0 for 20 cycles -> RspValid and RspIdx stable, InsReady=0, no second WrEn.
REQ-038 Flush=1 in IDLE after 8 inserts, then insert -> RspKind=NEW, WrIdx=0; a Flush pulse during SEARCH has no effect on that insert.
REQ-039 Drive Rst_n low at SEARCH entry 3 -> WrEn never asserted, all outputs at reset values, valid bits cleared.
